// File: rtl/fan_pkg.sv
// Shared constants for the fan tachometer monitor: register map, ID word,
// FSM encoding and STATUS bit positions.
package fan_pkg;

   localparam logic [2:0] AddrId         = 3'd0;
   localparam logic [2:0] AddrCtrl       = 3'd1;
   localparam logic [2:0] AddrTimeout    = 3'd2;
   localparam logic [2:0] AddrPeriod     = 3'd3;
   localparam logic [2:0] AddrPulseCount = 3'd4;
   localparam logic [2:0] AddrStatus     = 3'd5;

   localparam logic [31:0] FanId = 32'hEA68_0004;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArm     = 2'd1,
      StMeasure = 2'd2
   } fan_state_e;

   localparam int unsigned StatusStall = 0;
   localparam int unsigned StatusValid = 1;
   localparam int unsigned StatusLevel = 2;

endpackage

// File: rtl/tach_filter.sv
// Tach input conditioning: 2-flop synchroniser, programmable glitch filter and
// registered one-cycle pulse on each 1->0 transition of the filtered level.
module tach_filter
   import fan_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] filt_len,
   input  logic       tach_in,
   output logic       level,
   output logic       fall_pulse
);

   logic       sync1_q, sync2_q;
   logic       level_q, level_d;
   logic       prev_q;
   logic       fall_q;
   logic [7:0] fcnt_q, fcnt_d;

   // >= rather than == so lowering filt_len mid-count cannot strand the counter
   always_comb begin
      level_d = level_q;
      fcnt_d  = '0;
      if (sync2_q != level_q) begin
         if (fcnt_q >= filt_len) begin
            level_d = sync2_q;
         end else begin
            fcnt_d = fcnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         prev_q  <= 1'b1;
         fall_q  <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         sync1_q <= tach_in;
         sync2_q <= sync1_q;
         level_q <= level_d;
         prev_q  <= level_q;
         fall_q  <= prev_q & ~level_q;
         fcnt_q  <= fcnt_d;
      end
   end

   assign level      = level_q;
   assign fall_pulse = fall_q;

endmodule

// File: rtl/fan_tach_monitor.sv
// Avalon-MM fan tachometer monitor: register file, period-measurement FSM,
// pulse counter and stall interrupt.
module fan_tach_monitor
   import fan_pkg::*;
#(
   parameter logic [7:0]  FILT_RST    = 8'd16,
   parameter logic [31:0] TIMEOUT_RST = 32'h0100_0000
) (
   input  logic        csi_MCLK_clk,
   input  logic        rsi_MRST_reset_n,
   input  logic [2:0]  avs_ctrl_address,
   input  logic [31:0] avs_ctrl_writedata,
   input  logic [3:0]  avs_ctrl_byteenable,
   input  logic        avs_ctrl_write,
   input  logic        avs_ctrl_read,
   output logic [31:0] avs_ctrl_readdata,
   output logic        avs_ctrl_waitrequest,
   input  logic        tach,
   output logic        irq
);

   logic        enable_q, enable_d;
   logic        irq_en_q, irq_en_d;
   logic [7:0]  filt_len_q, filt_len_d;
   logic [31:0] timeout_q, timeout_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] period_q, period_d;
   logic [31:0] pcount_q, pcount_d;
   logic        valid_q, valid_d;
   logic        stall_q, stall_d;
   logic        irq_q, irq_d;
   logic [31:0] readdata_q, readdata_d;
   fan_state_e  state_q, state_d;

   logic        level;
   logic        fall_pulse;
   logic        edge_cnt;
   logic        stall_set;
   logic        timeout_hit;
   logic        wr_pcount;
   logic        w1c_stall;
   logic        unused_read;

   // Reads have no side effects, so readdata is refreshed regardless of the strobe
   assign unused_read = avs_ctrl_read;

   tach_filter u_tach_filter (
      .clk        (csi_MCLK_clk),
      .reset_n    (rsi_MRST_reset_n),
      .filt_len   (filt_len_q),
      .tach_in    (tach),
      .level      (level),
      .fall_pulse (fall_pulse)
   );

   assign wr_pcount = avs_ctrl_write && (avs_ctrl_address == AddrPulseCount);
   assign w1c_stall = avs_ctrl_write && (avs_ctrl_address == AddrStatus) &&
                      avs_ctrl_writedata[StatusStall];

   assign timeout_hit = (timeout_q != '0) &&
                        (({1'b0, cnt_q} + 33'd1) >= {1'b0, timeout_q});

   // Configuration registers with byte-lane enables
   always_comb begin
      enable_d   = enable_q;
      irq_en_d   = irq_en_q;
      filt_len_d = filt_len_q;
      timeout_d  = timeout_q;
      if (avs_ctrl_write) begin
         if (avs_ctrl_address == AddrCtrl) begin
            if (avs_ctrl_byteenable[0]) begin
               enable_d = avs_ctrl_writedata[0];
               irq_en_d = avs_ctrl_writedata[1];
            end
            if (avs_ctrl_byteenable[1]) begin
               filt_len_d = avs_ctrl_writedata[15:8];
            end
         end
         if (avs_ctrl_address == AddrTimeout) begin
            for (int b = 0; b < 4; b++) begin
               if (avs_ctrl_byteenable[b]) begin
                  timeout_d[b*8 +: 8] = avs_ctrl_writedata[b*8 +: 8];
               end
            end
         end
      end
   end

   // Measurement FSM
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      valid_d   = valid_q;
      edge_cnt  = 1'b0;
      stall_set = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d    = '0;
            period_d = '0;
            valid_d  = 1'b0;
            if (enable_q) begin
               state_d = StArm;
            end
         end
         StArm: begin
            if (fall_pulse) begin
               cnt_d    = '0;
               edge_cnt = 1'b1;
               state_d  = StMeasure;
            end else if (timeout_hit) begin
               stall_set = 1'b1;
               valid_d   = 1'b0;
               period_d  = '0;
               cnt_d     = '0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StMeasure: begin
            if (fall_pulse) begin
               period_d = cnt_q + 32'd1;
               valid_d  = 1'b1;
               cnt_d    = '0;
               edge_cnt = 1'b1;
            end else if (timeout_hit) begin
               stall_set = 1'b1;
               valid_d   = 1'b0;
               period_d  = '0;
               cnt_d     = '0;
               state_d   = StArm;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (!enable_q) begin
         state_d = StIdle;
      end
   end

   // A clear and a same-cycle edge leave the count at 1; a same-cycle stall beats W1C
   assign pcount_d = (wr_pcount ? 32'd0 : pcount_q) + {31'd0, edge_cnt};
   assign stall_d  = stall_set | (stall_q & ~w1c_stall);
   assign irq_d    = irq_en_q & stall_q;

   always_comb begin
      readdata_d = readdata_q;
      if (!avs_ctrl_write) begin
         unique case (avs_ctrl_address)
            AddrId:         readdata_d = FanId;
            AddrCtrl:       readdata_d = {16'd0, filt_len_q, 6'd0, irq_en_q, enable_q};
            AddrTimeout:    readdata_d = timeout_q;
            AddrPeriod:     readdata_d = period_q;
            AddrPulseCount: readdata_d = pcount_q;
            AddrStatus:     readdata_d = {29'd0, level, valid_q, stall_q};
            default:        readdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
      if (!rsi_MRST_reset_n) begin
         enable_q   <= 1'b0;
         irq_en_q   <= 1'b0;
         filt_len_q <= FILT_RST;
         timeout_q  <= TIMEOUT_RST;
         cnt_q      <= '0;
         period_q   <= '0;
         pcount_q   <= '0;
         valid_q    <= 1'b0;
         stall_q    <= 1'b0;
         irq_q      <= 1'b0;
         readdata_q <= '0;
         state_q    <= StIdle;
      end else begin
         enable_q   <= enable_d;
         irq_en_q   <= irq_en_d;
         filt_len_q <= filt_len_d;
         timeout_q  <= timeout_d;
         cnt_q      <= cnt_d;
         period_q   <= period_d;
         pcount_q   <= pcount_d;
         valid_q    <= valid_d;
         stall_q    <= stall_d;
         irq_q      <= irq_d;
         readdata_q <= readdata_d;
         state_q    <= state_d;
      end
   end

   assign avs_ctrl_readdata    = readdata_q;
   assign avs_ctrl_waitrequest = 1'b0;
   assign irq                  = irq_q;

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Directed self-checking bench for fan_tach_monitor.
module tb_fan_tach_monitor;

   logic        clk;
   logic        rst_n;
   logic [2:0]  address;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        write;
   logic        read;
   logic [31:0] readdata;
   logic        waitrequest;
   logic        tach;
   logic        irq;

   int tests = 0;
   int fails = 0;

   fan_tach_monitor dut (
      .csi_MCLK_clk         (clk),
      .rsi_MRST_reset_n     (rst_n),
      .avs_ctrl_address     (address),
      .avs_ctrl_writedata   (writedata),
      .avs_ctrl_byteenable  (byteenable),
      .avs_ctrl_write       (write),
      .avs_ctrl_read        (read),
      .avs_ctrl_readdata    (readdata),
      .avs_ctrl_waitrequest (waitrequest),
      .tach                 (tach),
      .irq                  (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
      address    = a;
      writedata  = d;
      byteenable = be;
      write      = 1'b1;
      tick(1);
      write      = 1'b0;
      byteenable = 4'hF;
   endtask

   task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
      address = a;
      read    = 1'b1;
      tick(1);
      read    = 1'b0;
      check(tag, readdata, exp);
   endtask

   // n falling edges, one every 2*half sample cycles
   task automatic wave(input int n, input int half);
      for (int i = 0; i < n; i++) begin
         tach = 1'b0;
         tick(half);
         tach = 1'b1;
         tick(half);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      tach       = 1'b1;
      write      = 1'b0;
      read       = 1'b0;
      address    = '0;
      writedata  = '0;
      byteenable = 4'hF;
      tick(3);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_rdata", readdata, 32'd0);
      rst_n = 1'b1;
      tick(2);

      rd_check("id", 3'd0, 32'hEA68_0004);
      rd_check("ctrl_rst", 3'd1, 32'h0000_1000);
      rd_check("timeout_rst", 3'd2, 32'h0100_0000);
      rd_check("period_rst", 3'd3, 32'd0);
      rd_check("pcount_rst", 3'd4, 32'd0);
      rd_check("status_rst", 3'd5, 32'd4);
      rd_check("addr6", 3'd6, 32'd0);
      check("irq_idle", {31'd0, irq}, 32'd0);

      // Square wave, filt_len=0, 1000-clock period
      bus_write(3'd1, 32'h0000_0001, 4'hF);
      wave(2, 500);
      rd_check("period_2edges", 3'd3, 32'd1000);
      rd_check("status_valid", 3'd5, 32'd6);
      wave(8, 500);
      rd_check("period_10edges", 3'd3, 32'd1000);
      rd_check("pcount_10", 3'd4, 32'd10);

      // Glitch filter with filt_len=16
      bus_write(3'd1, 32'h0000_1001, 4'hF);
      tach = 1'b0;
      tick(10);
      tach = 1'b1;
      tick(40);
      rd_check("glitch_rejected", 3'd4, 32'd10);
      tach = 1'b0;
      tick(20);
      tach = 1'b1;
      tick(40);
      rd_check("pulse_accepted", 3'd4, 32'd11);

      // Stall after 500 idle cycles from ARM
      bus_write(3'd2, 32'd500, 4'hF);
      bus_write(3'd1, 32'h0000_0000, 4'hF);
      bus_write(3'd1, 32'h0000_0003, 4'hF);
      tick(500);
      check("irq_before_stall", {31'd0, irq}, 32'd0);
      tick(1);
      check("irq_stall_cycle", {31'd0, irq}, 32'd0);
      tick(1);
      check("irq_after_stall", {31'd0, irq}, 32'd1);
      rd_check("status_stall", 3'd5, 32'd5);
      rd_check("period_stall", 3'd3, 32'd0);
      bus_write(3'd5, 32'd1, 4'hF);
      tick(1);
      check("irq_after_w1c", {31'd0, irq}, 32'd0);
      rd_check("status_w1c", 3'd5, 32'd4);

      // Edges land exactly on the timeout cycle: edge wins
      bus_write(3'd1, 32'h0000_0000, 4'hF);
      bus_write(3'd5, 32'd1, 4'hF);
      bus_write(3'd1, 32'h0000_0001, 4'hF);
      wave(4, 250);
      rd_check("status_edge_wins", 3'd5, 32'd6);
      rd_check("period_eq_timeout", 3'd3, 32'd500);

      // PULSE_COUNT write in the same cycle the edge is consumed
      tach = 1'b0;
      tick(4);
      bus_write(3'd4, 32'd0, 4'hF);
      rd_check("pcount_write_edge", 3'd4, 32'd1);
      tach = 1'b1;
      tick(30);

      // Asynchronous reset mid-measurement
      bus_write(3'd1, 32'h0000_0003, 4'hF);
      tick(600);
      check("irq_pre_reset", {31'd0, irq}, 32'd1);
      rd_check("id_pre_reset", 3'd0, 32'hEA68_0004);
      #2;
      rst_n = 1'b0;
      #1;
      check("irq_async_rst", {31'd0, irq}, 32'd0);
      check("rdata_async_rst", readdata, 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      rd_check("ctrl_after_rst", 3'd1, 32'h0000_1000);
      rd_check("status_after_rst", 3'd5, 32'd4);
      rd_check("period_after_rst", 3'd3, 32'd0);
      rd_check("pcount_after_rst", 3'd4, 32'd0);
      tach = 1'b0;
      tick(30);
      tach = 1'b1;
      tick(30);
      rd_check("pcount_idle_frozen", 3'd4, 32'd0);

      // Byte-lane enables
      bus_write(3'd2, 32'hFFFF_FFAA, 4'b0001);
      rd_check("timeout_be", 3'd2, 32'h0100_00AA);
      bus_write(3'd1, 32'hFFFF_FF03, 4'b0001);
      rd_check("ctrl_be", 3'd1, 32'h0000_1003);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
